// File: rtl/tl_rx_fc_credit_tracker.sv
// tl_rx_fc_credit_tracker: per-type RX flow-control credit tracking with modular receiver-overflow check
module tl_rx_fc_credit_tracker #(
    parameter int NUM_TYPES   = 3,
    parameter int TYP_W       = 2,
    parameter int INIT_HDR_W  = 8,
    parameter int INIT_DATA_W = 12,
    parameter int HDR_W       = 12,
    parameter int DATA_W      = 16,
    parameter int TLP_DATA_W  = 10
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            fc_init_load,
    input  logic [NUM_TYPES*INIT_HDR_W-1:0]  init_hdr_creds,
    input  logic [NUM_TYPES*INIT_DATA_W-1:0] init_data_creds,
    input  logic [NUM_TYPES*2-1:0]           init_hdr_scale,
    input  logic [NUM_TYPES*2-1:0]           init_data_scale,
    input  logic                            tlp_valid,
    input  logic [TYP_W-1:0]                tlp_typ,
    input  logic [TLP_DATA_W-1:0]           tlp_data_creds,
    input  logic                            rel_valid,
    input  logic [TYP_W-1:0]                rel_typ,
    input  logic [INIT_HDR_W-1:0]           rel_hdr_creds,
    input  logic [INIT_DATA_W-1:0]          rel_data_creds,
    input  logic                            err_clr,
    output logic                            fc_active,
    output logic                            tlp_accept,
    output logic                            flow_control_error,
    output logic [NUM_TYPES-1:0]            fc_err_status,
    output logic [TYP_W-1:0]                fc_err_typ,
    output logic [NUM_TYPES*HDR_W-1:0]      hdr_creds_allocated,
    output logic [NUM_TYPES*DATA_W-1:0]     data_creds_allocated
);
    typedef enum logic {FC_IDLE, FC_ACTIVE} fc_state_t;
    fc_state_t state, state_next;
    logic [HDR_W-1:0]  hdr_alloc [NUM_TYPES];
    logic [HDR_W-1:0]  hdr_rcv   [NUM_TYPES];
    logic [HDR_W-1:0]  hdr_next  [NUM_TYPES];
    logic [HDR_W-1:0]  hdr_room  [NUM_TYPES];
    logic [HDR_W-1:0]  hdr_init  [NUM_TYPES];
    logic [DATA_W-1:0] data_alloc[NUM_TYPES];
    logic [DATA_W-1:0] data_rcv  [NUM_TYPES];
    logic [DATA_W-1:0] data_next [NUM_TYPES];
    logic [DATA_W-1:0] data_room [NUM_TYPES];
    logic [DATA_W-1:0] data_init [NUM_TYPES];
    logic [NUM_TYPES-1:0] hdr_inf, data_inf, chk, rel, ovf;
    logic active, any_ok, any_ovf;
    assign active    = state == FC_ACTIVE;
    assign fc_active = active;
    assign any_ok    = |(chk & ~ovf);
    assign any_ovf   = |(chk & ovf);
    always_comb state_next = (state == FC_IDLE && fc_init_load) ? FC_ACTIVE : state;
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) state <= FC_IDLE;
        else         state <= state_next;
    genvar g;
    generate
        for (g = 0; g < NUM_TYPES; g++) begin : g_typ
            logic [1:0] hs, ds;
            assign hs = init_hdr_scale[g*2 +: 2];
            assign ds = init_data_scale[g*2 +: 2];
            assign hdr_init[g]  = HDR_W'(init_hdr_creds[g*INIT_HDR_W +: INIT_HDR_W]) << (hs == 2'b11 ? 4 : hs == 2'b10 ? 2 : 0);
            assign data_init[g] = DATA_W'(init_data_creds[g*INIT_DATA_W +: INIT_DATA_W]) << (ds == 2'b11 ? 4 : ds == 2'b10 ? 2 : 0);
            assign chk[g]       = active && tlp_valid && tlp_typ == TYP_W'(g);
            assign rel[g]       = active && rel_valid && rel_typ == TYP_W'(g);
            assign hdr_next[g]  = hdr_rcv[g] + HDR_W'(1);
            assign data_next[g] = data_rcv[g] + DATA_W'(tlp_data_creds);
            assign hdr_room[g]  = hdr_alloc[g] - hdr_next[g];
            assign data_room[g] = data_alloc[g] - data_next[g];
            // A "negative" modular distance means the TLP would exceed the advertised limit
            assign ovf[g] = (!hdr_inf[g] && hdr_room[g] >= {1'b1, {(HDR_W-1){1'b0}}}) ||
                            (!data_inf[g] && tlp_data_creds != '0 && data_room[g] >= {1'b1, {(DATA_W-1){1'b0}}});
            assign hdr_creds_allocated[g*HDR_W +: HDR_W]    = hdr_alloc[g];
            assign data_creds_allocated[g*DATA_W +: DATA_W] = data_alloc[g];
        end
    endgenerate
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            for (int i = 0; i < NUM_TYPES; i++) begin
                hdr_alloc[i]  <= '0;
                hdr_rcv[i]    <= '0;
                data_alloc[i] <= '0;
                data_rcv[i]   <= '0;
            end
            hdr_inf  <= '0;
            data_inf <= '0;
        end else if (!active) begin
            if (fc_init_load)
                for (int i = 0; i < NUM_TYPES; i++) begin
                    hdr_alloc[i]  <= hdr_init[i];
                    data_alloc[i] <= data_init[i];
                    hdr_rcv[i]    <= '0;
                    data_rcv[i]   <= '0;
                    hdr_inf[i]    <= hdr_init[i] == '0;
                    data_inf[i]   <= data_init[i] == '0;
                end
        end else
            for (int i = 0; i < NUM_TYPES; i++) begin
                if (rel[i] && !hdr_inf[i])           hdr_alloc[i]  <= hdr_alloc[i] + HDR_W'(rel_hdr_creds);
                if (rel[i] && !data_inf[i])          data_alloc[i] <= data_alloc[i] + DATA_W'(rel_data_creds);
                if (chk[i] && !ovf[i] && !hdr_inf[i])  hdr_rcv[i]  <= hdr_next[i];
                if (chk[i] && !ovf[i] && !data_inf[i]) data_rcv[i] <= data_next[i];
            end
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            tlp_accept         <= 1'b0;
            flow_control_error <= 1'b0;
            fc_err_status      <= '0;
            fc_err_typ         <= '0;
        end else begin
            tlp_accept         <= any_ok;
            flow_control_error <= any_ovf;
            if (any_ovf) begin
                fc_err_status <= (err_clr ? '0 : fc_err_status) | (chk & ovf);
                if (err_clr || fc_err_status == '0) fc_err_typ <= tlp_typ;
            end else if (err_clr) begin
                fc_err_status <= '0;
                fc_err_typ    <= '0;
            end
        end
endmodule

// File: doc/tl_rx_fc_credit_tracker.md
Name: tl_rx_fc_credit_tracker

Overview:
- Sequential RX flow-control credit tracker and receiver-overflow checker for NUM_TYPES credit types (default P/NP/CPL).
- Holds per-type header and data CREDITS_ALLOCATED and CREDITS_RECEIVED counters, loaded from InitFC values with scaled-FC support.
- Checks every received TLP against the modular overflow rule, drops offending TLPs and reports sticky per-type errors.
- Sits in tl_rx_write_handler_error_check between TLP decode and the RX buffers.

Parameters:
- NUM_TYPES, 3, number of credit types; index 0 = P, 1 = NP, 2 = CPL.
- TYP_W, 2, width of the type selects; must satisfy 2^TYP_W >= NUM_TYPES.
- INIT_HDR_W, 8, width of the InitFC header credit field.
- INIT_DATA_W, 12, width of the InitFC data credit field.
- HDR_W, 12, header counter width; must be >= INIT_HDR_W+4.
- DATA_W, 16, data counter width; must be >= INIT_DATA_W+4.
- TLP_DATA_W, 10, width of per-TLP data credit consumption.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- fc_init_load  in  1  one-cycle pulse: load initial allocations.
- init_hdr_creds  in  NUM_TYPES*INIT_HDR_W  per-type InitFC header values; type i at slice i.
- init_data_creds  in  NUM_TYPES*INIT_DATA_W  per-type InitFC data values.
- init_hdr_scale  in  NUM_TYPES*2  per-type header scale.
- init_data_scale  in  NUM_TYPES*2  per-type data scale.
- tlp_valid  in  1  received TLP credit check request.
- tlp_typ  in  TYP_W  credit type of the TLP.
- tlp_data_creds  in  TLP_DATA_W  data credits the TLP consumes; 0 for no payload.
- rel_valid  in  1  RX buffer credit release.
- rel_typ  in  TYP_W  credit type being released.
- rel_hdr_creds  in  INIT_HDR_W  header credits released.
- rel_data_creds  in  INIT_DATA_W  data credits released.
- err_clr  in  1  clears sticky status.
- fc_active  out  1  high once initialised.
- tlp_accept  out  1  registered pulse: last checked TLP passed.
- flow_control_error  out  1  registered pulse: last checked TLP overflowed.
- fc_err_status  out  NUM_TYPES  sticky per-type overflow flags.
- fc_err_typ  out  TYP_W  type of the first error since the last clear.
- hdr_creds_allocated  out  NUM_TYPES*HDR_W  allocated header counters, for UpdateFC.
- data_creds_allocated  out  NUM_TYPES*DATA_W  allocated data counters, for UpdateFC.

Behaviour:
- Reset values: all outputs and counters 0; FSM = FC_IDLE; all infinite flags 0.
- FSM FC_IDLE:
  - tlp_valid and rel_valid are ignored; no outputs pulse.
  - On fc_init_load, go to FC_ACTIVE next cycle (fc_active=1).
  - At the same time, per type: received=0; allocated = init value shifted left by 0 (scale 00/01), 2 (scale 10) or 4 (scale 11), zero-extended.
  - An init value of 0 sets that counter's infinite flag.
- FSM FC_ACTIVE:
  - fc_init_load is ignored. Only arst_n returns to FC_IDLE.
  - A reset mid-operation discards all counters and status.
- Check on tlp_valid with tlp_typ < NUM_TYPES:
  - hdr_next = hdr_received + 1; data_next = data_received + tlp_data_creds (modulo 2^W).
  - Header overflow if not infinite and ((hdr_allocated - hdr_next) mod 2^HDR_W) >= 2^(HDR_W-1). Data uses the same rule with DATA_W.
  - Data check is skipped when tlp_data_creds = 0.
- Result, one cycle latency, registered:
  - No overflow: tlp_accept=1; received counters take hdr_next/data_next.
  - Any overflow: flow_control_error=1; the TLP is dropped and its counters are unchanged.
  - On error, fc_err_status[typ] is set. fc_err_typ is captured only if fc_err_status was all-zero.
- tlp_typ >= NUM_TYPES: no check, no pulse, no update.
- Release on rel_valid, non-infinite counters only: allocated += rel_creds, modulo 2^W.
- Release and check on the same cycle, same type: the check uses the pre-release allocated value; both updates commit.
- Counters wrap modulo 2^W by design; wrap alone is never an error.
- err_clr clears fc_err_status and fc_err_typ. If an error registers in the same cycle, the error wins: its bit is set and fc_err_typ = its type.
- Infinite counters: never updated, never flagged.

Test Plan:
- Init P hdr=4 scale 01, data=0 -> hdr_alloc[P]=4, data infinite; 4 TLPs with 8 data creds each accepted; 5th -> flow_control_error=1 one cycle later, fc_err_status=001, fc_err_typ=0, hdr_received stays 4.
- NP data init=2 scale 11 -> data_alloc=32; TLP with 32 creds accepted; next with 1 cred -> error, status=010.
- CPL hdr alloc 4095 with received wrapped 4090->3 via releases -> TLPs accepted across wrap, no false error.
- Same-cycle release +1 and TLP on full P -> TLP flagged, allocated incremented; the next identical TLP is accepted.
- err_clr the same cycle as a CPL error with status=001 -> status=100, fc_err_typ=2.
- tlp_valid before fc_init_load, and tlp_typ=3 when active -> no pulses, counters unchanged; assert arst_n mid-stream -> all outputs 0, fc_active=0.
